ad7864_rd_buf: RTL

AD7864_RD_BUF -- requirements
Module: ad7864_rd_buf

---
 rtl/ad7864_rd_buf.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ad7864_rd_buf.sv
// rtl/ad7864_rd_buf.sv - AD7864 frame reader with 8-deep tagged sample FIFO for DSP readout
// Reads NCH channels per db_rdy edge, buffers {ch, sample}, presents head word to an async DSP.
module ad7864_rd_buf #(
  parameter int NCH   = 4,
  parameter int RD_LO = 3,
  parameter int RD_HI = 2
) (
  input  logic        clkin,
  input  logic        rst_bar,
  input  logic        db_rdy,
  input  logic [11:0] ad_db,
  output logic        ad_cs_bar,
  output logic        ad_rd_bar,
  input  logic        dsp_rd_bar,
  output logic [15:0] dsp_data,
  output logic        dsp_int_bar,
  output logic        ovf
);

  localparam int TMAX = (RD_LO > RD_HI) ? RD_LO : RD_HI;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] LO_LAST  = TW'(RD_LO - 1);
  localparam logic [TW-1:0] HI_LAST  = TW'(RD_HI - 1);
  localparam logic [1:0]    CH_LAST  = 2'(NCH - 1);
  localparam logic [3:0]    ROOM_MAX = 4'(8 - NCH);
  localparam logic [3:0]    NCH_W    = 4'(NCH);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    RD_LOW,
    RD_HIGH,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic [1:0]    ch, ch_nx;
  logic          capture;
  logic          cs_nx, rd_nx;

  logic db_s1, db_s2, db_prev, db_armed;
  logic [1:0] warm;
  logic rd_s1, rd_s2, rd_prev;
  logic trigger, pop, ovf_set;

  logic [13:0] mem [8];
  logic [2:0]  wp, rp;
  logic [3:0]  count;
  logic        wr_en, rd_en;

  // db_armed demands a low level seen after reset, so a db_rdy held high across release never fires.
  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      db_s1    <= 1'b0;
      db_s2    <= 1'b0;
      db_prev  <= 1'b0;
      db_armed <= 1'b0;
      warm     <= 2'b00;
      rd_s1    <= 1'b1;
      rd_s2    <= 1'b1;
      rd_prev  <= 1'b1;
    end else begin
      db_s1   <= db_rdy;
      db_s2   <= db_s1;
      db_prev <= db_s2;
      warm    <= {warm[0], 1'b1};
      if (warm[1] && !db_s2)
        db_armed <= 1'b1;
      rd_s1   <= dsp_rd_bar;
      rd_s2   <= rd_s1;
      rd_prev <= rd_s2;
    end
  end

  assign trigger = db_armed & db_s2 & ~db_prev;
  assign pop     = rd_prev & ~rd_s2;
  assign ovf_set = trigger & ((state != IDLE) | (count > ROOM_MAX));

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      state     <= IDLE;
      tmr       <= '0;
      ch        <= 2'd0;
      ad_cs_bar <= 1'b1;
      ad_rd_bar <= 1'b1;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      ch        <= ch_nx;
      ad_cs_bar <= cs_nx;
      ad_rd_bar <= rd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    ch_nx    = ch;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger && (count <= ROOM_MAX))
          state_nx = CS_SETUP;
      end
      CS_SETUP: begin
        state_nx = RD_LOW;
        ch_nx    = 2'd0;
        tmr_nx   = '0;
      end
      RD_LOW: begin
        if (tmr == LO_LAST) begin
          capture  = 1'b1;
          state_nx = RD_HIGH;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr + 1'b1;
        end
      end
      RD_HIGH: begin
        if (tmr == HI_LAST) begin
          tmr_nx = '0;
          if (ch == CH_LAST) begin
            state_nx = DONE;
          end else begin
            ch_nx    = ch + 2'd1;
            state_nx = RD_LOW;
          end
        end else begin
          tmr_nx = tmr + 1'b1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Strobes are registered from the next state so they change on the same edge as the state.
    cs_nx = !((state_nx == CS_SETUP) || (state_nx == RD_LOW) || (state_nx == RD_HIGH));
    rd_nx = !(state_nx == RD_LOW);
  end

  assign wr_en = capture;
  assign rd_en = pop & (count != 4'd0);

  always_ff @(posedge clkin) begin
    if (wr_en)
      mem[wp] <= {ch, ad_db};
  end

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      wp          <= 3'd0;
      rp          <= 3'd0;
      count       <= 4'd0;
      dsp_data    <= 16'h0000;
      dsp_int_bar <= 1'b1;
      ovf         <= 1'b0;
    end else begin
      if (wr_en)
        wp <= wp + 3'd1;
      if (rd_en)
        rp <= rp + 3'd1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      dsp_data    <= (count == 4'd0) ? 16'h0000 : {2'b00, mem[rp]};
      dsp_int_bar <= (count < NCH_W);
      if (ovf_set)
        ovf <= 1'b1;
    end
  end

endmodule
